// File: rtl/irq_arbiter.sv
// Memory-mapped fixed-priority interrupt controller: per-source mask, level/edge capture,
// and a non-nested claim/complete handshake presenting one registered request to the CPU.
module irq_arbiter #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:2]       addr,
    input  logic             We,
    input  logic             Re,
    input  logic [31:0]      Datain,
    output logic [31:0]      Dataout,
    input  logic [N_SRC-1:0] src_irq,
    output logic             cpu_irq
);
    localparam logic [1:0] A_MASK  = 2'd0;
    localparam logic [1:0] A_PEND  = 2'd1;
    localparam logic [1:0] A_CLAIM = 2'd2;
    localparam logic [1:0] A_EDGE  = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        PEND    = 3'b010,
        SERVICE = 3'b100
    } state_t;

    state_t           state_reg;
    logic [N_SRC-1:0] mask_reg;
    logic [N_SRC-1:0] edge_sel_reg;
    logic [N_SRC-1:0] pending_reg;
    logic [N_SRC-1:0] src_q_reg;
    logic [ID_W-1:0]  active_id_reg;
    logic             err_reg;
    logic             cpu_irq_reg;

    logic             wr_mask, wr_pend, wr_claim, wr_edge, rd_claim;
    logic [N_SRC-1:0] mask_eff, req_vec, claim_clr, pending_next;
    logic             req_any, claim_valid, claim_fire, complete_match;
    logic [ID_W-1:0]  claim_id;
    logic             unused_datain;

    assign wr_mask  = We && (addr == A_MASK);
    assign wr_pend  = We && (addr == A_PEND);
    assign wr_claim = We && (addr == A_CLAIM);
    assign wr_edge  = We && (addr == A_EDGE);
    // A simultaneous write wins over the claim side effect.
    assign rd_claim = Re && !We && (addr == A_CLAIM);

    // A mask being written this cycle already governs arbitration.
    assign mask_eff = wr_mask ? Datain[N_SRC-1:0] : mask_reg;
    assign req_vec  = pending_reg & mask_eff;
    assign req_any  = |req_vec;

    always_comb begin
        claim_valid = 1'b0;
        claim_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                claim_valid = 1'b1;
                claim_id    = ID_W'(i);
            end
        end
    end

    assign claim_fire     = rd_claim && (state_reg == PEND) && claim_valid;
    assign complete_match = wr_claim && (state_reg == SERVICE) && (Datain[ID_W-1:0] == active_id_reg);

    // Edge sources: new rising edge beats both W1C and claim clear in the same cycle.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
        assign claim_clr[gi]    = claim_fire && edge_sel_reg[gi] && (claim_id == ID_W'(gi));
        assign pending_next[gi] = edge_sel_reg[gi]
            ? ((pending_reg[gi] & ~(wr_pend & Datain[gi]) & ~claim_clr[gi])
               | (src_irq[gi] & ~src_q_reg[gi]))
            : src_irq[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_reg      <= '0;
            edge_sel_reg  <= '0;
            pending_reg   <= '0;
            src_q_reg     <= '0;
            active_id_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            src_q_reg   <= src_irq;
            pending_reg <= pending_next;
            if (wr_mask) mask_reg <= Datain[N_SRC-1:0];
            if (wr_edge) edge_sel_reg <= Datain[N_SRC-1:0];
            if (claim_fire) active_id_reg <= claim_id;
            if (wr_claim && Datain[29]) begin
                err_reg <= 1'b0;
            end else if (wr_claim && (state_reg == SERVICE) && !complete_match) begin
                err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cpu_irq_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_any) begin
                        state_reg   <= PEND;
                        cpu_irq_reg <= 1'b1;
                    end else begin
                        cpu_irq_reg <= 1'b0;
                    end
                end
                PEND: begin
                    if (claim_fire) begin
                        state_reg   <= SERVICE;
                        cpu_irq_reg <= 1'b0;
                    end else if (!req_any) begin
                        state_reg   <= IDLE;
                        cpu_irq_reg <= 1'b0;
                    end else begin
                        cpu_irq_reg <= 1'b1;
                    end
                end
                SERVICE: begin
                    cpu_irq_reg <= 1'b0;
                    if (complete_match) state_reg <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    cpu_irq_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_irq = cpu_irq_reg;

    always_comb begin
        Dataout = '0;
        case (addr)
            A_MASK:  Dataout = {{(32-N_SRC){1'b0}}, mask_reg};
            A_PEND:  Dataout = {{(32-N_SRC){1'b0}}, pending_reg};
            A_CLAIM: Dataout = {claim_valid, (state_reg == SERVICE), err_reg,
                                {(29-ID_W){1'b0}}, claim_id};
            A_EDGE:  Dataout = {{(32-N_SRC){1'b0}}, edge_sel_reg};
            default: Dataout = '0;
        endcase
    end

    assign unused_datain = ^{Datain[31:30], Datain[28:N_SRC]};
endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: per-scenario tasks, expectations queued at stimulus time and
// popped when the DUT output is sampled.
module tb_irq_arbiter;
    logic        clk;
    logic        reset;
    logic [3:2]  addr;
    logic        We;
    logic        Re;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic [5:0]  src_irq;
    logic        cpu_irq;

    int          compared;
    int          mismatched;
    logic [31:0] exp_q[$];
    logic [31:0] obs_v;
    logic [31:0] exp_v;

    irq_arbiter #(.N_SRC(6), .ID_W(3)) dut (
        .clk(clk), .reset(reset), .addr(addr), .We(We), .Re(Re),
        .Datain(Datain), .Dataout(Dataout), .src_irq(src_irq), .cpu_irq(cpu_irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; Datain = d; We = 1'b1;
        @(negedge clk);
        We = 1'b0; Datain = '0;
    endtask

    task automatic peek(input logic [1:0] a);
        addr = a;
        #1;
        obs_v = Dataout;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'd0);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL rst_cpu_irq: got %h want %h", obs_v, exp_v); end else $display("ok   rst_cpu_irq %h", obs_v);
        exp_q.push_back(32'd0); peek(2'd0); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL rst_mask: got %h want %h", obs_v, exp_v); end else $display("ok   rst_mask %h", obs_v);
        exp_q.push_back(32'd0); peek(2'd2); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL rst_claim: got %h want %h", obs_v, exp_v); end else $display("ok   rst_claim %h", obs_v);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_edge;
        wr(2'd3, 32'd1);
        wr(2'd0, 32'd1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        src_irq = 6'b000001;
        @(negedge clk);
        src_irq = '0;
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL edge_irq_k1: got %h want %h", obs_v, exp_v); end else $display("ok   edge_irq_k1 %h", obs_v);
        @(negedge clk);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL edge_irq_k2: got %h want %h", obs_v, exp_v); end else $display("ok   edge_irq_k2 %h", obs_v);
        exp_q.push_back(32'h8000_0000);
        addr = 2'd2; Re = 1'b1; #1; obs_v = Dataout; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL edge_claim: got %h want %h", obs_v, exp_v); end else $display("ok   edge_claim %h", obs_v);
        exp_q.push_back(32'd0);
        @(negedge clk);
        Re = 1'b0;
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL edge_irq_claimed: got %h want %h", obs_v, exp_v); end else $display("ok   edge_irq_claimed %h", obs_v);
        exp_q.push_back(32'h4000_0000); peek(2'd2); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL edge_in_service: got %h want %h", obs_v, exp_v); end else $display("ok   edge_in_service %h", obs_v);
        wr(2'd2, 32'd0);
        exp_q.push_back(32'd0); peek(2'd1); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL edge_pending_done: got %h want %h", obs_v, exp_v); end else $display("ok   edge_pending_done %h", obs_v);
        exp_q.push_back(32'd0); peek(2'd2); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL edge_idle_claim: got %h want %h", obs_v, exp_v); end else $display("ok   edge_idle_claim %h", obs_v);
    endtask

    task automatic test_priority;
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h3F);
        src_irq = 6'b100100;
        exp_q.push_back(32'd1);
        for (int i = 0; i < 4 && cpu_irq !== 1'b1; i++) @(negedge clk);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL prio_irq: got %h want %h", obs_v, exp_v); end else $display("ok   prio_irq %h", obs_v);
        exp_q.push_back(32'h8000_0002);
        addr = 2'd2; Re = 1'b1; #1; obs_v = Dataout; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL prio_claim: got %h want %h", obs_v, exp_v); end else $display("ok   prio_claim %h", obs_v);
        @(negedge clk);
        Re = 1'b0;
        exp_q.push_back(32'd0);
        wr(2'd2, 32'd2);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL prio_irq_after_done: got %h want %h", obs_v, exp_v); end else $display("ok   prio_irq_after_done %h", obs_v);
        exp_q.push_back(32'd1);
        for (int i = 0; i < 3 && cpu_irq !== 1'b1; i++) @(negedge clk);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL prio_irq_reassert: got %h want %h", obs_v, exp_v); end else $display("ok   prio_irq_reassert %h", obs_v);
        exp_q.push_back(32'h8000_0002);
        addr = 2'd2; Re = 1'b1; #1; obs_v = Dataout; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL prio_claim_again: got %h want %h", obs_v, exp_v); end else $display("ok   prio_claim_again %h", obs_v);
        @(negedge clk);
        Re = 1'b0;
        src_irq = '0;
        wr(2'd2, 32'd2);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mask;
        wr(2'd0, 32'd0);
        src_irq = 6'b001000;
        repeat (3) @(negedge clk);
        exp_q.push_back(32'h08); peek(2'd1); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL mask_pending: got %h want %h", obs_v, exp_v); end else $display("ok   mask_pending %h", obs_v);
        exp_q.push_back(32'd0);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL mask_irq_masked: got %h want %h", obs_v, exp_v); end else $display("ok   mask_irq_masked %h", obs_v);
        exp_q.push_back(32'd1);
        wr(2'd0, 32'h08);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL mask_irq_unmasked: got %h want %h", obs_v, exp_v); end else $display("ok   mask_irq_unmasked %h", obs_v);
        exp_q.push_back(32'd0);
        wr(2'd0, 32'd0);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL mask_irq_remasked: got %h want %h", obs_v, exp_v); end else $display("ok   mask_irq_remasked %h", obs_v);
        src_irq = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bad_complete;
        wr(2'd0, 32'h3F);
        src_irq = 6'b000010;
        exp_q.push_back(32'd1);
        for (int i = 0; i < 4 && cpu_irq !== 1'b1; i++) @(negedge clk);
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL bad_irq: got %h want %h", obs_v, exp_v); end else $display("ok   bad_irq %h", obs_v);
        exp_q.push_back(32'h8000_0001);
        addr = 2'd2; Re = 1'b1; #1; obs_v = Dataout; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL bad_claim: got %h want %h", obs_v, exp_v); end else $display("ok   bad_claim %h", obs_v);
        @(negedge clk);
        Re = 1'b0;
        wr(2'd2, 32'd4);
        exp_q.push_back(32'd3); peek(2'd2); obs_v = {30'b0, obs_v[30:29]}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL bad_err_set: got %h want %h", obs_v, exp_v); end else $display("ok   bad_err_set %h", obs_v);
        src_irq = '0;
        wr(2'd2, 32'd1);
        exp_q.push_back(32'd1); peek(2'd2); obs_v = {30'b0, obs_v[30:29]}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL bad_err_sticky: got %h want %h", obs_v, exp_v); end else $display("ok   bad_err_sticky %h", obs_v);
        wr(2'd2, 32'h2000_0000);
        exp_q.push_back(32'd0); peek(2'd2); obs_v = {30'b0, obs_v[30:29]}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL bad_err_clear: got %h want %h", obs_v, exp_v); end else $display("ok   bad_err_clear %h", obs_v);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_collisions;
        src_irq = 6'b000001;
        for (int i = 0; i < 4 && cpu_irq !== 1'b1; i++) @(negedge clk);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h8000_0000);
        addr = 2'd2; Datain = 32'd0; We = 1'b1; Re = 1'b1;
        @(negedge clk);
        We = 1'b0; Re = 1'b0;
        obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL coll_we_re_irq: got %h want %h", obs_v, exp_v); end else $display("ok   coll_we_re_irq %h", obs_v);
        peek(2'd2); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL coll_we_re_claim: got %h want %h", obs_v, exp_v); end else $display("ok   coll_we_re_claim %h", obs_v);
        addr = 2'd2; Re = 1'b1;
        @(negedge clk);
        Re = 1'b0;
        src_irq = '0;
        wr(2'd2, 32'd0);
        repeat (2) @(negedge clk);
        wr(2'd0, 32'd0);
        wr(2'd3, 32'h04);
        exp_q.push_back(32'h04);
        src_irq = 6'b000100; addr = 2'd1; Datain = 32'h04; We = 1'b1;
        @(negedge clk);
        We = 1'b0;
        peek(2'd1); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL coll_set_w1c: got %h want %h", obs_v, exp_v); end else $display("ok   coll_set_w1c %h", obs_v);
        exp_q.push_back(32'd0);
        wr(2'd1, 32'h04);
        peek(2'd1); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL coll_w1c_only: got %h want %h", obs_v, exp_v); end else $display("ok   coll_w1c_only %h", obs_v);
        src_irq = '0;
        wr(2'd3, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        wr(2'd0, 32'h3F);
        src_irq = 6'b001000;
        for (int i = 0; i < 4 && cpu_irq !== 1'b1; i++) @(negedge clk);
        addr = 2'd2; Re = 1'b1;
        @(negedge clk);
        Re = 1'b0;
        exp_q.push_back(32'd1); peek(2'd2); obs_v = {31'b0, obs_v[30]}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL rmid_in_service: got %h want %h", obs_v, exp_v); end else $display("ok   rmid_in_service %h", obs_v);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1 reset = 1'b1;
        #1 obs_v = {31'b0, cpu_irq}; exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL rmid_cpu_irq: got %h want %h", obs_v, exp_v); end else $display("ok   rmid_cpu_irq %h", obs_v);
        peek(2'd0); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL rmid_mask: got %h want %h", obs_v, exp_v); end else $display("ok   rmid_mask %h", obs_v);
        peek(2'd1); exp_v = exp_q.pop_front(); compared++;
        if (obs_v !== exp_v) begin mismatched++; $display("FAIL rmid_pending: got %h want %h", obs_v, exp_v); end else $display("ok   rmid_pending %h", obs_v);
        @(negedge clk);
        src_irq = '0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        reset = 1'b1; addr = '0; We = 1'b0; Re = 1'b0; Datain = '0; src_irq = '0;
        test_reset();
        test_edge();
        test_priority();
        test_mask();
        test_bad_complete();
        test_collisions();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
